// File: rtl/mmio_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_pkg
// Description : Shared definitions for the memory-mapped UART transmitter:
//               register offsets, STATUS bit indices, serializer states and
//               a STATUS packing helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_uart_tx_pkg;

    // Register offsets inside the 16-byte window
    localparam logic [3:0] c_off_txdata  = 4'h0;
    localparam logic [3:0] c_off_status  = 4'h4;
    localparam logic [3:0] c_off_bauddiv = 4'h8;

    // STATUS bit positions
    localparam int c_stat_full  = 0;
    localparam int c_stat_empty = 1;
    localparam int c_stat_busy  = 2;
    localparam int c_stat_ovr   = 3;

    // Data bits per frame (8N1)
    localparam int c_data_bits = 8;

    // Serializer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Assemble the STATUS read word from its flags
    function automatic logic [31:0] pack_status(
        input logic ovr,
        input logic busy,
        input logic empty,
        input logic full
    );
        logic [31:0] word;
        word                = '0;
        word[c_stat_ovr]    = ovr;
        word[c_stat_busy]   = busy;
        word[c_stat_empty]  = empty;
        word[c_stat_full]   = full;
        return word;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx_sync_fifo
// Description : Small synchronous first-word-fall-through FIFO. Pointers
//               carry one extra wrap bit so full/empty come from comparing
//               the MSBs. A push while full is accepted only when a pop
//               happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_pw = c_aw + 1;
    localparam logic [c_pw-1:0] c_ptr_one = 1;

    logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Flags: equal pointers mean empty; equal index with differing wrap bit means full
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                   (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

    // Head of queue is always visible so the consumer can load it on the pop edge
    assign dout = mem_q[rd_ptr_q[c_aw-1:0]];

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointer values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
    end

    // Next storage contents: write the pushed entry at the write index
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wr_ptr_q[c_aw-1:0]] = din;
        end
    end

    // Pointer registers; reset discards all queued entries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage registers; contents are only meaningful between the pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : mmio_uart_tx
// Description : Memory-mapped 8N1 UART transmitter for the core's data bus.
//               Stores to TXDATA are queued in a small FIFO and shifted out
//               LSB first on tx. STATUS and BAUDDIV are read combinationally
//               so single-cycle loads complete in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       sel;
    logic [3:0] offset;
    logic       txdata_we;
    logic       status_we;
    logic       bauddiv_we;

    assign sel        = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset     = addr[3:0];
    assign txdata_we  = we & sel & (offset == c_off_txdata);
    assign status_we  = we & sel & (offset == c_off_status);
    assign bauddiv_we = we & sel & (offset == c_off_bauddiv);

    // Only the low half-word of store data is ever consumed
    logic unused_wdata;
    assign unused_wdata = ^wdata[31:16];

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic       fifo_pop;
    logic [7:0] fifo_dout;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overrun;

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (txdata_we),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A store is lost only when the FIFO is full and nothing drains this cycle
    assign overrun = txdata_we & fifo_full & ~fifo_pop;

    // ------------------------------------------------------------------
    // Control registers: BAUDDIV and sticky overrun flag
    // ------------------------------------------------------------------
    logic [15:0] bauddiv_q, bauddiv_d;
    logic        ovr_q, ovr_d;

    // Register updates; a fresh overrun beats a simultaneous clear
    always_comb begin
        bauddiv_d = bauddiv_q;
        ovr_d     = ovr_q;
        if (bauddiv_we) begin
            bauddiv_d = wdata[15:0];
        end
        if (status_we && wdata[c_stat_ovr]) begin
            ovr_d = 1'b0;
        end
        if (overrun) begin
            ovr_d = 1'b1;
        end
    end

    // Control register storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bauddiv_q <= DEFAULT_DIV;
            ovr_q     <= 1'b0;
        end else begin
            bauddiv_q <= bauddiv_d;
            ovr_q     <= ovr_d;
        end
    end

    // ------------------------------------------------------------------
    // Serializer: baud down-counter, bit counter, shift register, tx
    // ------------------------------------------------------------------
    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        bit_end;

    localparam logic [2:0] c_last_bit = 3'(c_data_bits - 1);

    // A bit period ends when the counter, loaded with BAUDDIV at the bit start, reaches zero
    assign bit_end = (baud_cnt_q == 16'd0);

    // Next-state logic; the counter reloads from the live BAUDDIV at every bit start,
    // so a divider change lands on the next bit boundary
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_dout;
                    baud_cnt_d = bauddiv_q;
                    tx_d       = 1'b0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_cnt_d = bauddiv_q;
                    bit_cnt_d  = 3'd0;
                    tx_d       = shift_q[0];
                    state_d    = ST_DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_cnt_d = bauddiv_q;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == c_last_bit) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next frame when data is waiting
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_d    = fifo_dout;
                        baud_cnt_d = bauddiv_q;
                        tx_d       = 1'b0;
                        state_d    = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Serializer state and registered line output; reset forces the line idle at once
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            baud_cnt_q <= 16'd0;
            bit_cnt_q  <= 3'd0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic        busy;
    logic [31:0] status_word;

    assign busy        = (state_q != ST_IDLE);
    assign status_word = pack_status(ovr_q, busy, fifo_empty, fifo_full);
    assign tx          = tx_q;
    assign irq         = fifo_empty & ~busy;

    // Combinational read mux; unselected or unmapped addresses read zero
    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (offset)
                c_off_status:  rdata = status_word;
                c_off_bauddiv: rdata = {16'd0, bauddiv_q};
                default:       rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_uart_tx
// Description : Self-checking bench for mmio_uart_tx. A timeline model turns
//               every accepted byte into a frame start time and ten slot
//               lengths (BAUDDIV in effect at each slot start, plus one) and
//               predicts tx, irq and STATUS cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd433)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising edge
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // ---------------- reference model ----------------
    logic [7:0] m_byte[$];
    int         m_push[$];
    int         m_start[$];
    int         m_end[$];
    int         h_t[$];
    int         h_v[$];
    logic       m_ovr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    function automatic void model_reset();
        m_byte.delete(); m_push.delete(); m_start.delete(); m_end.delete();
        h_t.delete(); h_v.delete();
        h_t.push_back(-1); h_v.push_back(433);
        m_ovr = 1'b0;
    endfunction

    // Divider used by a bit that starts at edge b: last write strictly before b
    function automatic int div_at(input int b);
        int v;
        v = h_v[0];
        for (int i = 0; i < h_t.size(); i++) if (h_t[i] < b) v = h_v[i];
        return v;
    endfunction

    // Frames start one edge after their push, or at the end of the previous frame
    function automatic void sched();
        int prev_end;
        int s;
        int b;
        m_start.delete(); m_end.delete();
        prev_end = -1000;
        for (int i = 0; i < m_push.size(); i++) begin
            s = (m_push[i] + 1 > prev_end) ? m_push[i] + 1 : prev_end;
            b = s;
            for (int k = 0; k < 10; k++) b += div_at(b) + 1;
            m_start.push_back(s);
            m_end.push_back(b);
            prev_end = b;
        end
    endfunction

    function automatic logic exp_tx(input int n);
        int b;
        int len;
        logic [7:0] bt;
        sched();
        for (int i = 0; i < m_start.size(); i++) begin
            if (m_start[i] <= n && n < m_end[i]) begin
                b = m_start[i];
                for (int k = 0; k < 10; k++) begin
                    len = div_at(b) + 1;
                    if (n < b + len) begin
                        if (k == 0) return 1'b0;
                        if (k == 9) return 1'b1;
                        bt = m_byte[i];
                        return bt[k-1];
                    end
                    b += len;
                end
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int n);
        sched();
        for (int i = 0; i < m_start.size(); i++)
            if (m_start[i] <= n && n < m_end[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int exp_count(input int n);
        int c;
        c = 0;
        sched();
        for (int i = 0; i < m_push.size(); i++)
            if (m_push[i] <= n && m_start[i] > n) c++;
        return c;
    endfunction

    function automatic logic exp_irq(input int n);
        return (exp_count(n) == 0) && !exp_busy(n);
    endfunction

    function automatic logic [31:0] exp_status(input int n);
        int c;
        c = exp_count(n);
        return {28'd0, m_ovr, exp_busy(n), (c == 0), (c == DEPTH)};
    endfunction

    // Apply one bus store that took effect at edge t
    function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input int t);
        int  cnt;
        bit  pop;
        if (a[31:4] != BASE[31:4]) return;
        case (a[3:0])
            4'h0: begin
                sched();
                cnt = 0;
                pop = 1'b0;
                for (int i = 0; i < m_push.size(); i++) begin
                    if (m_push[i] < t && m_start[i] >= t) cnt++;
                    if (m_start[i] == t) pop = 1'b1;
                end
                if (cnt < DEPTH || pop) begin
                    m_byte.push_back(d[7:0]);
                    m_push.push_back(t);
                end else begin
                    m_ovr = 1'b1;
                end
            end
            4'h4: if (d[3]) m_ovr = 1'b0;
            4'h8: begin
                h_t.push_back(t);
                h_v.push_back(int'(d[15:0]));
            end
            default: ;
        endcase
    endfunction

    // ---------------- line monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            check("tx", 32'(tx), 32'(exp_tx(cycle)));
            check("irq", 32'(irq), 32'(exp_irq(cycle)));
        end
    end

    // ---------------- bus tasks (entered and left on a falling edge) ----------------
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clk);
        we = 1'b0;
        model_write(a, d, cycle);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        we   = 1'b0;
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            if (exp_irq(cycle) && irq) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) check("idle_timeout", 32'd0, 32'd1);
        m_byte.delete(); m_push.delete();
    endtask

    // ---------------- stimulus ----------------
    logic [9:0] a5_frame;
    logic       txs [0:63];
    int         busy_cnt;
    int         rises;
    logic       prev_busy;
    int         op;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        addr  = 32'd0;
        wdata = 32'd0;
        we    = 1'b0;
        model_reset();

        // Reset values, seen while reset is still asserted
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd1);
        bus_read("rst_status", BASE + 32'h4, 32'h2);
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        @(negedge clk);
        bus_read("status_after_rst", BASE + 32'h4, 32'h2);
        bus_read("bauddiv_default", BASE + 32'h8, 32'd433);
        bus_read("txdata_reads0", BASE + 32'h0, 32'd0);

        // Single 0xA5 frame at BAUDDIV=3
        bus_write(BASE + 32'h8, 32'd3);
        bus_read("bauddiv_3", BASE + 32'h8, 32'd3);
        bus_write(BASE + 32'h0, 32'h0000_00A5);
        busy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            addr = BASE + 32'h4;
            #1;
            if (rdata[2]) busy_cnt++;
            txs[i] = tx;
            @(negedge clk);
        end
        check("a5_busy_len", 32'(busy_cnt), 32'd40);
        a5_frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) check("a5_bit", 32'(txs[4*k + 3]), 32'(a5_frame[k]));
        wait_idle();

        // Six stores back to back: five accepted, one overrun, frames chained
        for (int i = 0; i < 6; i++) bus_write(BASE + 32'h0, 32'($urandom_range(0, 255)));
        busy_cnt = 0;
        rises    = 0;
        prev_busy = 1'b1;
        for (int i = 0; i < 260; i++) begin
            addr = BASE + 32'h4;
            #1;
            if (rdata[2]) busy_cnt++;
            if (rdata[2] && !prev_busy) rises++;
            prev_busy = rdata[2];
            if (i == 0) check("ovr_set", 32'(rdata[3]), 32'd1);
            @(negedge clk);
        end
        check("ovr_busy_len", 32'(busy_cnt), 32'd196);
        check("ovr_no_gap", 32'(rises), 32'd0);
        wait_idle();
        bus_read("ovr_sticky", BASE + 32'h4, 32'h0000_000A);
        bus_write(BASE + 32'h4, 32'h8);
        bus_read("ovr_cleared", BASE + 32'h4, 32'h2);

        // BAUDDIV 3 -> 1 during data bit 2 of 0x55 (frame starts one edge after push)
        bus_write(BASE + 32'h0, 32'h55);
        repeat (13) @(negedge clk);
        bus_write(BASE + 32'h8, 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            txs[i] = tx;
        end
        check("div_bit2_tail", 32'(txs[1]), 32'd1);
        check("div_bit3_a", 32'(txs[2]), 32'd0);
        check("div_bit3_b", 32'(txs[3]), 32'd0);
        check("div_bit4_a", 32'(txs[4]), 32'd1);
        check("div_bit4_b", 32'(txs[5]), 32'd1);
        check("div_bit5_a", 32'(txs[6]), 32'd0);
        wait_idle();

        // Reset during data bit 3 of a 0x00 frame with more bytes queued
        bus_write(BASE + 32'h8, 32'd3);
        bus_write(BASE + 32'h0, 32'h00);
        bus_write(BASE + 32'h0, 32'hFF);
        bus_write(BASE + 32'h0, 32'h0F);
        repeat (16) @(negedge clk);
        check("tx_before_rst", 32'(tx), 32'd0);
        mon_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("tx_async_rst", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        bus_read("status_post_rst", BASE + 32'h4, 32'h2);
        bus_read("bauddiv_post_rst", BASE + 32'h8, 32'd433);
        mon_en = 1'b1;
        repeat (150) @(negedge clk);

        // Out-of-window and reserved accesses
        bus_read("oow_read", 32'h0000_2004, 32'd0);
        bus_read("rsvd_read", BASE + 32'hC, 32'd0);
        bus_write(32'h0000_2000, 32'h5A);
        bus_write(32'h0000_2008, 32'd7);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        repeat (20) @(negedge clk);
        bus_read("oow_status", BASE + 32'h4, 32'h2);
        bus_read("oow_bauddiv", BASE + 32'h8, 32'd433);

        // Randomized traffic with divider changes, clears and status reads
        bus_write(BASE + 32'h8, 32'd1);
        for (int r = 0; r < 80; r++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0: bus_write(BASE + 32'h8, 32'($urandom_range(0, 3)));
                1: bus_write(BASE + 32'h4, $urandom);
                2: bus_read("rnd_status", BASE + 32'h4, exp_status(cycle));
                3: bus_read("rnd_bauddiv", BASE + 32'h8, 32'(h_v[h_v.size()-1]));
                default: bus_write(BASE + 32'h0, $urandom);
            endcase
            repeat ($urandom_range(0, 20)) @(negedge clk);
            bus_read("rnd_status_b", BASE + 32'h4, exp_status(cycle));
        end
        wait_idle();
        bus_read("final_status", BASE + 32'h4, exp_status(cycle));

        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
